dmem_responder: RTL and testbench

//  Responder side of the processor data-memory port: services address_dmem/data/wren with

---
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus a 4-word MMIO window (TX byte FIFO, status,
// cycle counter, drop counter). Read data is registered, one cycle of latency.
module dmem_responder #(
    parameter int          RAM_AW    = 12,
    parameter int          FIFO_AW   = 3,
    parameter logic [31:0] MMIO_BASE = 32'h0000FF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int RAM_DEPTH  = 1 << RAM_AW;
    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic ram;
        logic txdata;
        logic status;
        logic cycles;
        logic drops;
    } dec_t;

    dec_t dec;

    always_comb begin
        dec        = '0;
        dec.ram    = address_dmem < 32'(RAM_DEPTH);
        dec.txdata = address_dmem == MMIO_BASE;
        dec.status = address_dmem == MMIO_BASE + 32'd1;
        dec.cycles = address_dmem == MMIO_BASE + 32'd2;
        dec.drops  = address_dmem == MMIO_BASE + 32'd3;
    end

    // ---------------- RAM ----------------
    logic [31:0]       ram [RAM_DEPTH];
    logic [31:0]       ram_rdata;
    logic [RAM_AW-1:0] ram_addr;

    assign ram_addr = address_dmem[RAM_AW-1:0];

    // Nonblocking read beside the write gives read-old-data on a same-address collision.
    always_ff @(posedge clock) begin
        if (wren && dec.ram)
            ram[ram_addr] <= data;
        ram_rdata <= ram[ram_addr];
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               empty, full, push, pop, drop;

    assign empty    = count == '0;
    assign full     = count == CNT_FULL;
    assign push     = wren && dec.txdata && !full;
    assign drop     = wren && dec.txdata && full;
    assign pop      = !empty && tx_ready;
    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= data[7:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ---------------- counters ----------------
    logic [31:0] cycle_cnt, drop_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            cycle_cnt <= (wren && dec.cycles) ? 32'd0 : cycle_cnt + 32'd1;
            if (wren && dec.drops)
                drop_cnt <= '0;
            else if (drop && drop_cnt != 32'hFFFF_FFFF)
                drop_cnt <= drop_cnt + 32'd1;
        end
    end

    // ---------------- read path ----------------
    logic [31:0] mmio_rdata, mmio_q;
    logic        ram_sel_q;

    always_comb begin
        mmio_rdata = '0;
        if (dec.status)
            mmio_rdata = {16'b0, 8'(count), 6'b0, full, empty};
        else if (dec.cycles)
            mmio_rdata = cycle_cnt;
        else if (dec.drops)
            mmio_rdata = drop_cnt;
    end

    // The RAM output register has no reset, so the select flop masks it out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ram_sel_q <= 1'b0;
            mmio_q    <= '0;
        end else begin
            ram_sel_q <= dec.ram;
            mmio_q    <= dec.ram ? 32'd0 : mmio_rdata;
        end
    end

    assign q_dmem = ram_sel_q ? ram_rdata : mmio_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: read-data scoreboard plus a byte-queue model of the TX FIFO.
module tb_dmem_responder;
    localparam logic [31:0] BASE   = 32'h0000FF00;
    localparam logic [31:0] A_TX   = BASE;
    localparam logic [31:0] A_ST   = BASE + 32'd1;
    localparam logic [31:0] A_CYC  = BASE + 32'd2;
    localparam logic [31:0] A_DRP  = BASE + 32'd3;
    localparam logic [31:0] A_IDLE = 32'h0010_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q_dmem;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] rdq [$];
    logic [7:0]  txq [$];

    dmem_responder #(.RAM_AW(12), .FIFO_AW(3), .MMIO_BASE(BASE)) dut (
        .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
        .wren(wren), .q_dmem(q_dmem), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: called just after a rising edge, returns just after the next one.
    task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic c, input logic [31:0] e, input string tag);
        logic        full_b, mpop;
        logic [31:0] exp;
        wren = w; address_dmem = a; data = d;
        full_b = txq.size() == 8;
        if (txq.size() != 0) begin
            chk({tag, "_txv"}, 32'(tx_valid), 32'd1);
            chk({tag, "_txd"}, 32'(tx_data), 32'(txq[0]));
        end else begin
            chk({tag, "_txv"}, 32'(tx_valid), 32'd0);
            chk({tag, "_txd"}, 32'(tx_data), 32'd0);
        end
        if (c) rdq.push_back(e);
        mpop = (txq.size() != 0) && tx_ready;
        @(posedge clock); #1;
        wren = 1'b0;
        if (mpop) void'(txq.pop_front());
        if (w && a == A_TX && !full_b) txq.push_back(d[7:0]);
        if (c) begin
            exp = rdq.pop_front();
            chk(tag, q_dmem, exp);
        end
    endtask

    initial begin
        // 1: reset
        address_dmem = A_IDLE;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_q", q_dmem, 32'd0);
        chk("rst_txv", 32'(tx_valid), 32'd0);
        chk("rst_txd", 32'(tx_data), 32'd0);
        reset = 1'b1;
        op(0, A_ST, 0, 1, 32'h0000_0001, "status_rst");
        op(0, A_IDLE, 0, 1, 32'd0, "idle_rd");

        // 2: RAM write, read, read-during-write
        op(1, 32'd5, 32'hDEADBEEF, 0, 0, "ram_wr");
        op(0, 32'd5, 0, 1, 32'hDEADBEEF, "ram_rd");
        op(1, 32'd5, 32'h1, 1, 32'hDEADBEEF, "ram_rdw_old");
        op(0, 32'd5, 0, 1, 32'h1, "ram_rd_new");

        // 3: overfill the FIFO, then drain
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            op(1, A_TX, 32'h41 + i, 1, 32'd0, "push");
        op(0, A_ST, 0, 1, 32'h0000_0802, "status_full");
        op(0, A_DRP, 0, 1, 32'd1, "drops_one");
        tx_ready = 1'b1;
        for (int i = 0; i < 20 && txq.size() != 0; i++)
            op(0, A_IDLE, 0, 1, 32'd0, "drain");
        chk("drain_bound", txq.size(), 32'd0);
        op(0, A_DRP, 32'd0, 1, 32'd1, "drops_hold");
        op(1, A_DRP, 32'd0, 0, 0, "drops_clr");

        // 4: concurrent push/pop at count 4
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            op(1, A_TX, 32'h50 + i, 0, 0, "prefill");
        op(0, A_ST, 0, 1, 32'h0000_0400, "status_four");
        tx_ready = 1'b1;
        for (int i = 0; i < 6; i++)
            op(1, A_TX, 32'h60 + i, 0, 0, "conc");
        tx_ready = 1'b0;
        op(0, A_ST, 0, 1, 32'h0000_0400, "status_conc");
        op(0, A_DRP, 0, 1, 32'd0, "drops_zero");
        tx_ready = 1'b1;
        for (int i = 0; i < 20 && txq.size() != 0; i++)
            op(0, A_IDLE, 0, 0, 0, "drain2");
        chk("drain2_bound", txq.size(), 32'd0);
        tx_ready = 1'b0;

        // 5: cycle counter clear, out-of-range access
        op(1, A_CYC, 32'hFFFF_FFFF, 0, 0, "cyc_clr");
        op(0, A_IDLE, 0, 0, 0, "cyc_w1");
        op(0, A_IDLE, 0, 0, 0, "cyc_w2");
        op(0, A_CYC, 0, 1, 32'd2, "cyc_rd");
        op(1, 32'd0, 32'hCAFE0000, 0, 0, "ram0_wr");
        op(0, 32'h00FF_FFFF, 0, 1, 32'd0, "oor_rd");
        op(1, 32'h00FF_FFFF, 32'h12345678, 0, 0, "oor_wr");
        op(0, BASE + 32'd4, 0, 1, 32'd0, "mmio_hole");
        op(0, 32'd0, 0, 1, 32'hCAFE0000, "ram0_keep");

        // 6: async reset with bytes queued
        for (int i = 0; i < 5; i++)
            op(1, A_TX, 32'h70 + i, 0, 0, "q5");
        op(0, A_ST, 0, 1, 32'h0000_0500, "status_five");
        #2 reset = 1'b0;
        #1;
        chk("arst_txv", 32'(tx_valid), 32'd0);
        chk("arst_txd", 32'(tx_data), 32'd0);
        chk("arst_q", q_dmem, 32'd0);
        txq.delete();
        @(posedge clock); #1;
        reset = 1'b1;
        op(0, A_ST, 0, 1, 32'h0000_0001, "status_after");
        op(0, 32'd5, 0, 1, 32'h1, "ram_survives");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
